// File: rtl/fpu_seq_pkg.sv
// Shared FPU sequencer types: funct codes, FSM states, unit select and the canonical NaN.
// Imported by the sequencer top; no logic or latency of its own.
package fpu_seq_pkg;

    localparam logic [5:0]  FPU_ADD   = 6'b000000;
    localparam logic [5:0]  FPU_SUB   = 6'b000001;
    localparam logic [5:0]  FPU_MUL   = 6'b000010;
    localparam logic [5:0]  FPU_DIV   = 6'b000011;
    localparam logic [5:0]  FPU_MOV   = 6'b000110;
    localparam logic [31:0] CANON_NAN = 32'h7FC00000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {U_ADD, U_MUL, U_DIV, U_NONE} unit_sel_t;

    // MOV and unrecognised codes need no execution unit.
    function automatic unit_sel_t unit_of(input logic [5:0] funct);
        unit_sel_t u;
        case (funct)
            FPU_ADD, FPU_SUB: u = U_ADD;
            FPU_MUL:          u = U_MUL;
            FPU_DIV:          u = U_DIV;
            default:          u = U_NONE;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/fpu_seq_if.sv
// Request, unit-issue and writeback signals between the core, the sequencer and the FP units.
// slave = sequencer side, master = core/unit side.
interface fpu_seq_if;

    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_funct;
    logic [4:0]  req_fd;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic [31:0] u_a;
    logic [31:0] u_b;
    logic        u_sub;
    logic        add_tvalid;
    logic        mul_tvalid;
    logic        div_tvalid;
    logic        add_rvalid;
    logic        mul_rvalid;
    logic        div_rvalid;
    logic [31:0] add_rdata;
    logic [31:0] mul_rdata;
    logic [31:0] div_rdata;

    logic        wb_valid;
    logic [4:0]  wb_fd;
    logic [31:0] wb_data;
    logic        wb_err;
    logic        busy;

    modport slave (
        input  req_valid, req_funct, req_fd, req_a, req_b,
        input  add_rvalid, mul_rvalid, div_rvalid, add_rdata, mul_rdata, div_rdata,
        output req_ready, u_a, u_b, u_sub, add_tvalid, mul_tvalid, div_tvalid,
        output wb_valid, wb_fd, wb_data, wb_err, busy
    );

    modport master (
        output req_valid, req_funct, req_fd, req_a, req_b,
        output add_rvalid, mul_rvalid, div_rvalid, add_rdata, mul_rdata, div_rdata,
        input  req_ready, u_a, u_b, u_sub, add_tvalid, mul_tvalid, div_tvalid,
        input  wb_valid, wb_fd, wb_data, wb_err, busy
    );

endinterface

// File: rtl/fpu_seq_timer.sv
// WAIT watchdog: counts enabled cycles from a clear; expire flags the TIMEOUT-th enabled cycle.
// Combinational expire, no backpressure.
module fpu_seq_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // The current enabled cycle is the TIMEOUT-th one when cnt holds TIMEOUT-1.
    assign expire = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_seq.sv
// FPU issue sequencer: one op in flight; wb at 1 cycle (MOV/unknown) or 2+L after accept; req_ready only in IDLE.
// Define FPU_SEQ_TIMEOUT_EN to bound WAIT at TIMEOUT cycles with an error writeback.
module fpu_seq
    import fpu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       CLK,
    input  logic       RST,
    fpu_seq_if.slave   bus
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fpu_seq: TIMEOUT must be at least 1");
    end

    state_t      state, state_nxt;
    unit_sel_t   unit_q, req_unit;
    logic [4:0]  fd_q;
    logic        accept, sel_rvalid, tmo_expire, wb_load;
    logic [31:0] sel_rdata, wb_data_nxt;
    logic [4:0]  wb_fd_nxt;
    logic        wb_err_nxt;

    assign accept   = bus.req_valid && (state == IDLE);
    assign req_unit = unit_of(bus.req_funct);

    // Capture is open in ISSUE as well, so a zero-latency unit is not missed.
    always_comb begin
        sel_rvalid = 1'b0;
        sel_rdata  = bus.add_rdata;
        if (state == ISSUE || state == WAIT) begin
            case (unit_q)
                U_ADD:   begin sel_rvalid = bus.add_rvalid; sel_rdata = bus.add_rdata; end
                U_MUL:   begin sel_rvalid = bus.mul_rvalid; sel_rdata = bus.mul_rdata; end
                U_DIV:   begin sel_rvalid = bus.div_rvalid; sel_rdata = bus.div_rdata; end
                default: ;
            endcase
        end
    end

`ifdef FPU_SEQ_TIMEOUT_EN
    fpu_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (state != WAIT),
        .en     (state == WAIT),
        .expire (tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (req_unit == U_NONE) ? DONE : ISSUE;
            ISSUE:   state_nxt = sel_rvalid ? DONE : WAIT;
            WAIT:    if (sel_rvalid || tmo_expire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.busy       = (state != IDLE);
        bus.wb_valid   = (state == DONE);
        bus.add_tvalid = (state == ISSUE) && (unit_q == U_ADD);
        bus.mul_tvalid = (state == ISSUE) && (unit_q == U_MUL);
        bus.div_tvalid = (state == ISSUE) && (unit_q == U_DIV);
    end

    // Writeback payload is registered on the edge that enters DONE; a non-result exit from WAIT is a timeout.
    assign wb_load = (state != DONE) && (state_nxt == DONE);

    always_comb begin
        wb_fd_nxt   = fd_q;
        wb_data_nxt = sel_rdata;
        wb_err_nxt  = 1'b0;
        if (state == IDLE) begin
            wb_fd_nxt   = bus.req_fd;
            wb_err_nxt  = (bus.req_funct != FPU_MOV);
            wb_data_nxt = wb_err_nxt ? CANON_NAN : bus.req_b;
        end else if (!sel_rvalid) begin
            wb_data_nxt = CANON_NAN;
            wb_err_nxt  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.u_a     <= '0;
            bus.u_b     <= '0;
            bus.u_sub   <= 1'b0;
            unit_q      <= U_NONE;
            fd_q        <= '0;
            bus.wb_fd   <= '0;
            bus.wb_data <= '0;
            bus.wb_err  <= 1'b0;
        end else begin
            if (accept) begin
                bus.u_a   <= bus.req_a;
                bus.u_b   <= bus.req_b;
                bus.u_sub <= (bus.req_funct == FPU_SUB);
                unit_q    <= req_unit;
                fd_q      <= bus.req_fd;
            end
            if (wb_load) begin
                bus.wb_fd   <= wb_fd_nxt;
                bus.wb_data <= wb_data_nxt;
                bus.wb_err  <= wb_err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fpu_seq.sv
// Directed bench for fpu_seq: table of ops with hand-computed writeback timing/data, plus reset-in-WAIT sequence.
module tb_fpu_seq;
    import fpu_seq_pkg::*;

    localparam int TMO = 5;

    logic CLK = 1'b0;
    logic RST;

    fpu_seq_if bus();

    fpu_seq #(.TIMEOUT(TMO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  funct;
        logic [4:0]  fd;
        logic [31:0] a;
        logic [31:0] b;
        int          unit;      // 0 add, 1 mul, 2 div, 3 none
        int          lat;
        logic [31:0] rdata;
        bit          noise;     // pulse a foreign unit's rvalid during WAIT
        logic        exp_sub;
        int          exp_cyc;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];
    int total = 0;
    int bad = 0;
    logic [31:0] last_wb;
    bit have_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_rvalid();
        bus.add_rvalid = 1'b0;
        bus.mul_rvalid = 1'b0;
        bus.div_rvalid = 1'b0;
    endtask

    task automatic drive_rvalid(input int u, input logic [31:0] d);
        case (u)
            0: begin bus.add_rvalid = 1'b1; bus.add_rdata = d; end
            1: begin bus.mul_rvalid = 1'b1; bus.mul_rdata = d; end
            default: begin bus.div_rvalid = 1'b1; bus.div_rdata = d; end
        endcase
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int wb_c, t_c, t_cnt, t_u, rdy_bad;
        logic [31:0] wb_d, ua_obs;
        logic [4:0]  wb_f;
        logic        wb_e, sub_obs;
        wb_c = -1; t_c = -1; t_cnt = 0; t_u = 3; rdy_bad = 0;
        wb_d = '0; wb_f = '0; wb_e = 1'b0; ua_obs = '0; sub_obs = 1'b0;

        @(negedge CLK);
        check($sformatf("v%0d ready_at_accept", idx), {31'd0, bus.req_ready}, 32'd1);
        if (have_last) begin
            check($sformatf("v%0d wb_valid_low", idx), {31'd0, bus.wb_valid}, 32'd0);
            check($sformatf("v%0d wb_data_hold", idx), bus.wb_data, last_wb);
        end
        bus.req_funct = v.funct;
        bus.req_fd    = v.fd;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.req_valid = 1'b1;

        for (int c = 1; c <= 150 && wb_c < 0; c++) begin
            @(negedge CLK);
            bus.req_valid = 1'b0;
            bus.req_fd    = ~v.fd;
            bus.req_b     = 32'h12345678;
            bus.req_a     = 32'h87654321;
            bus.req_funct = FPU_MOV;
            clear_rvalid();
            if (v.unit != 3 && c == 1 + v.lat) drive_rvalid(v.unit, v.rdata);
            if (v.noise && c == 2) drive_rvalid((v.unit == 1) ? 0 : 1, 32'hDEADBEEF);
            if (bus.add_tvalid) begin t_cnt++; t_c = c; t_u = 0; end
            if (bus.mul_tvalid) begin t_cnt++; t_c = c; t_u = 1; end
            if (bus.div_tvalid) begin t_cnt++; t_c = c; t_u = 2; end
            if (c == 1) begin
                ua_obs  = bus.u_a;
                sub_obs = bus.u_sub;
            end
            if (bus.req_ready || !bus.busy) rdy_bad++;
            if (bus.wb_valid) begin
                wb_c = c; wb_d = bus.wb_data; wb_f = bus.wb_fd; wb_e = bus.wb_err;
            end
        end
        clear_rvalid();

        check($sformatf("v%0d wb_cycle", idx), wb_c, v.exp_cyc);
        check($sformatf("v%0d wb_data", idx), wb_d, v.exp_data);
        check($sformatf("v%0d wb_fd", idx), {27'd0, wb_f}, {27'd0, v.fd});
        check($sformatf("v%0d wb_err", idx), {31'd0, wb_e}, {31'd0, v.exp_err});
        check($sformatf("v%0d busy_window", idx), rdy_bad, 0);
        check($sformatf("v%0d u_a", idx), ua_obs, v.a);
        check($sformatf("v%0d u_sub", idx), {31'd0, sub_obs}, {31'd0, v.exp_sub});
        check($sformatf("v%0d tvalid_count", idx), t_cnt, (v.unit == 3) ? 0 : 1);
        if (v.unit != 3) begin
            check($sformatf("v%0d tvalid_unit", idx), t_u, v.unit);
            check($sformatf("v%0d tvalid_cycle", idx), t_c, 1);
        end
        last_wb   = v.exp_data;
        have_last = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        check({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " strobes"}, {28'd0, bus.wb_valid, bus.add_tvalid, bus.mul_tvalid, bus.div_tvalid}, 32'd0);
        check({tag, " u_a"}, bus.u_a, 32'd0);
        check({tag, " u_b"}, bus.u_b, 32'd0);
        check({tag, " u_sub_wb_err"}, {30'd0, bus.u_sub, bus.wb_err}, 32'd0);
        check({tag, " wb_fd"}, {27'd0, bus.wb_fd}, 32'd0);
        check({tag, " wb_data"}, bus.wb_data, 32'd0);
    endtask

    initial begin
        vec_t v;
        RST = 1'b1;
        bus.req_valid = 1'b0; bus.req_funct = '0; bus.req_fd = '0; bus.req_a = '0; bus.req_b = '0;
        bus.add_rdata = '0; bus.mul_rdata = '0; bus.div_rdata = '0;
        clear_rvalid();

        //           funct    fd    a             b             unit lat rdata         noise sub cyc data          err
        vecs[0] = '{FPU_ADD, 5'd3,  32'h3F800000, 32'h40000000, 0,   0,  32'h40400000, 0,    0,  2,  32'h40400000, 0};
        vecs[1] = '{FPU_SUB, 5'd4,  32'h40400000, 32'h3F800000, 0,   2,  32'h40000000, 0,    1,  4,  32'h40000000, 0};
        vecs[2] = '{FPU_MUL, 5'd9,  32'h40000000, 32'h40400000, 1,   3,  32'h40C00000, 0,    0,  5,  32'h40C00000, 0};
        vecs[3] = '{FPU_DIV, 5'd31, 32'h3F800000, 32'h40000000, 2,   12, 32'h3F000000, 1,    0,  14, 32'h3F000000, 0};
        vecs[4] = '{FPU_MOV, 5'd7,  32'h00000000, 32'hC0A00000, 3,   0,  32'h0,        0,    0,  1,  32'hC0A00000, 0};
        vecs[5] = '{6'h3F,   5'd2,  32'h11111111, 32'h22222222, 3,   0,  32'h0,        0,    0,  1,  CANON_NAN,    1};
        vecs[6] = '{FPU_DIV, 5'd5,  32'h40C00000, 32'h40000000, 2,   0,  32'h40400000, 0,    0,  2,  32'h40400000, 0};
        vecs[7] = '{FPU_MUL, 5'd11, 32'h3FC00000, 32'h40000000, 1,   5,  32'h40400000, 0,    0,  7,  32'h40400000, 0};
        vecs[8] = '{FPU_DIV, 5'd12, 32'h41200000, 32'h40000000, 2,   40, 32'h40A00000, 0,    0,  42, 32'h40A00000, 0};
        vecs[9] = '{6'h04,   5'd30, 32'h33333333, 32'h44444444, 3,   0,  32'h0,        0,    0,  1,  CANON_NAN,    1};

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check_all_zero("reset");

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
`ifdef FPU_SEQ_TIMEOUT_EN
            // A unit slower than TIMEOUT loses to the watchdog; equal latency still delivers the result.
            if (v.unit != 3 && v.lat > TMO) begin
                v.exp_cyc  = 2 + TMO;
                v.exp_data = CANON_NAN;
                v.exp_err  = 1'b1;
            end
`endif
            run_vec(i, v);
        end

        // Reset while a DIV sits in WAIT; its late result must be dropped.
        @(negedge CLK);
        bus.req_funct = FPU_DIV; bus.req_fd = 5'd6;
        bus.req_a = 32'h40800000; bus.req_b = 32'h40000000;
        bus.req_valid = 1'b1;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        check("rst_seq issued", {31'd0, bus.div_tvalid}, 32'd1);
        repeat (2) @(negedge CLK);
        check("rst_seq waiting", {31'd0, bus.busy}, 32'd1);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check_all_zero("after_rst");
        drive_rvalid(2, 32'h40000000);
        @(negedge CLK);
        clear_rvalid();
        check("late_rvalid no_wb", {31'd0, bus.wb_valid}, 32'd0);
        check("late_rvalid idle", {31'd0, bus.req_ready}, 32'd1);
        @(negedge CLK);
        check("late_rvalid no_wb2", {31'd0, bus.wb_valid}, 32'd0);
        check("late_rvalid wb_data", bus.wb_data, 32'd0);
        last_wb = 32'd0;

        run_vec(10, '{FPU_MOV, 5'd13, 32'h0BADF00D, 32'h3F800000, 3, 0, 32'h0, 0, 0, 1, 32'h3F800000, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
